rotate_ddr_wrbuf: RTL and testbench

ROTATE_DDR_WRBUF -- requirements
Module: rotate_ddr_wrbuf

---
 rtl/rotate_ddr_wrbuf_if.sv | 25 ++
 rtl/rotate_ddr_wrbuf.sv | 99 +++++++++
 tb/tb_rotate_ddr_wrbuf.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rotate_ddr_wrbuf_if.sv
// Write-side bus of the rotator output buffer: rotator write port plus DDRAM write port.
interface rotate_ddr_wrbuf_if;
    logic        in_we;
    logic [28:0] in_addr;
    logic [63:0] in_din;
    logic [7:0]  in_be;

    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;
    logic        DDRAM_RD;

    modport slave (
        input  in_we, in_addr, in_din, in_be, DDRAM_BUSY,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD
    );

    modport master (
        output in_we, in_addr, in_din, in_be, DDRAM_BUSY,
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD
    );
endinterface

// File: rtl/rotate_ddr_wrbuf.sv
// Circular write buffer between the rotator and the DDRAM controller, with optional
// byte-lane merging of repeated writes into the newest queued entry.
module rotate_ddr_wrbuf #(
    parameter int DEPTH = 16,
    parameter int MERGE = 1
) (
    input  logic                CLK_VIDEO,
    input  logic                reset,
    rotate_ddr_wrbuf_if.slave   bus,
    output logic                DDRAM_CLK,
    output logic [6:0]          level,
    output logic                overflow,
    input  logic                ovf_clr
);
    localparam int AW = $clog2(DEPTH);

    logic [28:0]   mem_addr [DEPTH];
    logic [63:0]   mem_data [DEPTH];
    logic [7:0]    mem_be   [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] tail;
    logic [6:0]    count;

    logic empty;
    logic full;
    logic pop;
    logic tail_hit;
    logic merge;
    logic push;
    logic drop;

    assign tail     = wr_ptr - AW'(1);
    assign empty    = (count == 7'd0);
    assign full     = (count == 7'(DEPTH));
    assign pop      = !empty && !bus.DDRAM_BUSY;
    assign tail_hit = (mem_addr[tail] == bus.in_addr);

    // Requiring two entries keeps merges off the head, which the controller may be sampling.
    assign merge = (MERGE != 0) && bus.in_we && (count >= 7'd2) && tail_hit;
    assign push  = bus.in_we && !merge && (!full || pop);
    assign drop  = bus.in_we && !merge && full && !pop;

    always_ff @(posedge CLK_VIDEO) begin
        if (push) begin
            mem_addr[wr_ptr] <= bus.in_addr;
            mem_data[wr_ptr] <= bus.in_din;
            mem_be[wr_ptr]   <= bus.in_be;
        end else if (merge) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (bus.in_be[i]) begin
                    mem_data[tail][8*i +: 8] <= bus.in_din[8*i +: 8];
                end
            end
            mem_be[tail] <= mem_be[tail] | bus.in_be;
        end
    end

    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 7'd1;
                2'b01:   count <= count - 7'd1;
                default: count <= count;
            endcase
        end
    end

    // A drop on the same edge as a clear leaves the flag set.
    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    assign DDRAM_CLK          = CLK_VIDEO;
    assign bus.DDRAM_BURSTCNT = 8'd1;
    assign bus.DDRAM_RD       = 1'b0;
    assign bus.DDRAM_WE       = !empty;
    assign bus.DDRAM_ADDR     = mem_addr[rd_ptr];
    assign bus.DDRAM_DIN      = mem_data[rd_ptr];
    assign bus.DDRAM_BE       = mem_be[rd_ptr];
    assign level              = count;
endmodule

// File: tb/tb_rotate_ddr_wrbuf.sv
// Directed bench for rotate_ddr_wrbuf: vector table plus fill/drain, overflow and reset sequences.
module tb_rotate_ddr_wrbuf;
    logic       clk;
    logic       rst;
    logic       ddram_clk;
    logic [6:0] level;
    logic       overflow;
    logic       ovf_clr;

    int unsigned checks;
    int unsigned errors;

    rotate_ddr_wrbuf_if bus ();

    rotate_ddr_wrbuf #(.DEPTH(16), .MERGE(1)) dut (
        .CLK_VIDEO (clk),
        .reset     (rst),
        .bus       (bus.slave),
        .DDRAM_CLK (ddram_clk),
        .level     (level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
        logic        busy;
        logic        clr;
        logic        e_we;
        logic [28:0] e_addr;
        logic [63:0] e_din;
        logic [7:0]  e_be;
        logic [6:0]  e_lvl;
        logic        e_ovf;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are applied #1 after an edge, then held across exactly one rising edge.
    task automatic step(input logic we, input logic [28:0] a, input logic [63:0] d,
                        input logic [7:0] be, input logic busy, input logic clr);
        bus.in_we      = we;
        bus.in_addr    = a;
        bus.in_din     = d;
        bus.in_be      = be;
        bus.DDRAM_BUSY = busy;
        ovf_clr        = clr;
        @(posedge clk);
        #1;
        bus.in_we = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    function automatic logic [63:0] fdata(input int unsigned i);
        return 64'h0123_4567_0000_0000 | 64'(i * 32'h0101_0001);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst            = 1'b1;
        ovf_clr        = 1'b0;
        bus.in_we      = 1'b0;
        bus.in_addr    = '0;
        bus.in_din     = '0;
        bus.in_be      = '0;
        bus.DDRAM_BUSY = 1'b0;

        vt[0]  = '{1, 29'h100, 64'hFEED_0000_0000_0100, 8'h0F, 0, 0,  1, 29'h100, 64'hFEED_0000_0000_0100, 8'h0F, 7'd1, 0};
        vt[1]  = '{0, 29'h0,   64'h0,                   8'h00, 0, 0,  0, 29'h0,   64'h0,                   8'h00, 7'd0, 0};
        vt[2]  = '{1, 29'h200, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1, 0,  1, 29'h200, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 7'd1, 0};
        vt[3]  = '{1, 29'h300, 64'h1111_1111_2222_2222, 8'h0F, 1, 0,  1, 29'h200, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 7'd2, 0};
        vt[4]  = '{1, 29'h300, 64'h3333_3333_4444_4444, 8'hF0, 1, 0,  1, 29'h200, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 7'd2, 0};
        vt[5]  = '{0, 29'h0,   64'h0,                   8'h00, 0, 0,  1, 29'h300, 64'h3333_3333_2222_2222, 8'hFF, 7'd1, 0};
        vt[6]  = '{0, 29'h0,   64'h0,                   8'h00, 0, 0,  0, 29'h0,   64'h0,                   8'h00, 7'd0, 0};
        vt[7]  = '{1, 29'h400, 64'hC1C1_C1C1_C1C1_C1C1, 8'h0F, 1, 0,  1, 29'h400, 64'hC1C1_C1C1_C1C1_C1C1, 8'h0F, 7'd1, 0};
        vt[8]  = '{1, 29'h400, 64'hC2C2_C2C2_C2C2_C2C2, 8'hF0, 1, 0,  1, 29'h400, 64'hC1C1_C1C1_C1C1_C1C1, 8'h0F, 7'd2, 0};
        vt[9]  = '{0, 29'h0,   64'h0,                   8'h00, 0, 0,  1, 29'h400, 64'hC2C2_C2C2_C2C2_C2C2, 8'hF0, 7'd1, 0};
        vt[10] = '{0, 29'h0,   64'h0,                   8'h00, 0, 0,  0, 29'h0,   64'h0,                   8'h00, 7'd0, 0};
        vt[11] = '{1, 29'h500, 64'h0000_0000_0000_00AA, 8'h01, 1, 0,  1, 29'h500, 64'h0000_0000_0000_00AA, 8'h01, 7'd1, 0};
        vt[12] = '{1, 29'h600, 64'h0000_0000_0000_00BB, 8'h01, 1, 0,  1, 29'h500, 64'h0000_0000_0000_00AA, 8'h01, 7'd2, 0};
        vt[13] = '{1, 29'h600, 64'h0000_0000_0000_CC00, 8'h02, 0, 0,  1, 29'h600, 64'h0000_0000_0000_CCBB, 8'h03, 7'd1, 0};
        vt[14] = '{0, 29'h0,   64'h0,                   8'h00, 0, 1,  0, 29'h0,   64'h0,                   8'h00, 7'd0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_we",    64'(bus.DDRAM_WE), 64'd0);
        chk("reset_level", 64'(level),        64'd0);
        rst = 1'b0;
        chk("reset_ovf",   64'(overflow),     64'd0);
        chk("burstcnt",    64'(bus.DDRAM_BURSTCNT), 64'd1);
        chk("rd_const",    64'(bus.DDRAM_RD), 64'd0);
        chk("ddram_clk",   64'(ddram_clk),    64'(clk));

        for (int i = 0; i < 15; i++) begin
            step(vt[i].we, vt[i].addr, vt[i].din, vt[i].be, vt[i].busy, vt[i].clr);
            chk($sformatf("v%0d_we", i),    64'(bus.DDRAM_WE), 64'(vt[i].e_we));
            chk($sformatf("v%0d_level", i), 64'(level),        64'(vt[i].e_lvl));
            chk($sformatf("v%0d_ovf", i),   64'(overflow),     64'(vt[i].e_ovf));
            if (vt[i].e_we) begin
                chk($sformatf("v%0d_addr", i), 64'(bus.DDRAM_ADDR), 64'(vt[i].e_addr));
                chk($sformatf("v%0d_din", i),  bus.DDRAM_DIN,       vt[i].e_din);
                chk($sformatf("v%0d_be", i),   64'(bus.DDRAM_BE),   64'(vt[i].e_be));
            end
        end

        // Fill to 16 while stalled, 17th word dropped, then drain in order.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 29'h1000 + 29'(i), fdata(i), 8'hFF, 1'b1, 1'b0);
        end
        chk("fill_level", 64'(level),    64'd16);
        chk("fill_ovf",   64'(overflow), 64'd0);
        step(1'b1, 29'h2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1, 1'b0);
        chk("drop_level", 64'(level),    64'd16);
        chk("drop_ovf",   64'(overflow), 64'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_we", i),   64'(bus.DDRAM_WE),   64'd1);
            chk($sformatf("drain%0d_addr", i), 64'(bus.DDRAM_ADDR), 64'(29'h1000 + 29'(i)));
            chk($sformatf("drain%0d_din", i),  bus.DDRAM_DIN,       fdata(i));
            step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        end
        chk("drained_we",    64'(bus.DDRAM_WE), 64'd0);
        chk("drained_level", 64'(level),        64'd0);
        chk("ovf_sticky",    64'(overflow),     64'd1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        chk("ovf_clr", 64'(overflow), 64'd0);

        // Clear on the same edge as a drop: the drop wins.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 29'h3000 + 29'(i), fdata(i + 100), 8'hFF, 1'b1, 1'b0);
        end
        step(1'b1, 29'h3FFF, 64'h0, 8'hFF, 1'b1, 1'b1);
        chk("setwins_ovf",   64'(overflow), 64'd1);
        chk("setwins_level", 64'(level),    64'd16);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        chk("clr2_ovf", 64'(overflow), 64'd0);

        // Full FIFO, pop and push on the same edge.
        step(1'b1, 29'h3010, fdata(116), 8'hFF, 1'b0, 1'b0);
        chk("fullpush_level", 64'(level),          64'd16);
        chk("fullpush_ovf",   64'(overflow),       64'd0);
        chk("fullpush_head",  64'(bus.DDRAM_ADDR), 64'(29'h3001));
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain2_%0d_addr", i), 64'(bus.DDRAM_ADDR), 64'(29'h3000 + 29'(i)));
            chk($sformatf("drain2_%0d_din", i),  bus.DDRAM_DIN,       fdata(i + 100));
            step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        end
        chk("drain2_level", 64'(level), 64'd0);

        // Asynchronous reset with entries queued and the controller stalled.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 29'h4000 + 29'(i), fdata(i + 200), 8'hFF, 1'b1, 1'b0);
        end
        chk("pre_rst_level", 64'(level), 64'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_we",    64'(bus.DDRAM_WE), 64'd0);
        chk("async_rst_level", 64'(level),        64'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle_we", 64'(bus.DDRAM_WE), 64'd0);
        step(1'b1, 29'h5000, 64'h5555_0000_5555_0000, 8'h0F, 1'b0, 1'b0);
        chk("post_rst_we",    64'(bus.DDRAM_WE),   64'd1);
        chk("post_rst_addr",  64'(bus.DDRAM_ADDR), 64'(29'h5000));
        chk("post_rst_be",    64'(bus.DDRAM_BE),   64'h0F);
        chk("post_rst_level", 64'(level),          64'd1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("post_rst_pop", 64'(level), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
